clip_transport_ctrl: RTL and testbench
======================================

// Module: clip_transport_ctrl
// PURPOSE
// - Multi-clip record/playback transport for the audio recorder, between user controls and the sample store.
// - Edge-detects play/record commands and latches the selected clip.
// - On each sample tick, writes mic samples into the clip's memory region or reads them back to the speaker path.
// - Keeps a per-clip recorded-length table so playback stops at the recorded end.
// - Generalises the two-clip flow to NUM_CLIPS clips of 2**DEPTH_W samples.
// PARAMETERS
// - NUM_CLIPS  4   number of clips; power of two >= 2; CLIP_W = $clog2(NUM_CLIPS)
// - DEPTH_W    16  log2 of samples per clip; ADDR_W = CLIP_W + DEPTH_W
// - SAMPLE_W   16  sample width
// PORTS
// - clock_i         in   1         system clock (100 MHz)
// - reset_n_i       in   1         asynchronous active-low reset
// - play_i          in   1         play command level, synchronous to clock_i; acts on rising edge
// - record_i        in   1         record command level, synchronous to clock_i; acts on rising edge
// - play_clip_i     in   CLIP_W    clip index for play
// - record_clip_i   in   CLIP_W    clip index for record
// - sample_tick_i   in   1         one-cycle sample-rate strobe
// - mic_sample_i    in   SAMPLE_W  current microphone sample
// - mem_we_o        out  1         write strobe, one cycle
// - mem_re_o        out  1         read strobe, one cycle; mem_rdata_i is valid the next cycle
// - mem_addr_o      out  ADDR_W    {clip, offset}
// - mem_wdata_o     out  SAMPLE_W  write data
// - mem_rdata_i     in   SAMPLE_W  read data
// - spk_sample_o    out  SAMPLE_W  playback sample, held between updates
// - spk_valid_o     out  1         one-cycle pulse when spk_sample_o updates
// - state_o         out  2         0 IDLE, 1 RECORD, 2 PLAY
// - clip_o          out  CLIP_W    active or last-used clip (seven-segment display)
// - empty_err_o     out  1         one-cycle pulse: play requested on a zero-length clip
// BEHAVIOUR
// - Reset values: all outputs 0, state IDLE, offset 0, all length-table entries 0, edge detectors 0.
// - Edge detect: cmd_rise = cmd_i & ~cmd_q, with cmd_q registered.
// - The clip index is sampled only in the cycle of the accepted edge.
// - IDLE -> RECORD on record rise: clip := record_clip_i, offset := 0.
// - IDLE -> PLAY on play rise, when len[play_clip_i] != 0: clip := play_clip_i, offset := 0.
// - Play rise on a zero-length clip: stay IDLE; pulse empty_err_o in the next cycle.
// - Simultaneous play and record rise in IDLE: record wins.
// - RECORD, each sample_tick_i:
//   - mem_we_o=1, mem_addr_o={clip,offset}, mem_wdata_o=mic_sample_i, all registered (one cycle after the tick).
//   - offset += 1.
// - RECORD exit:
//   - record rise: len[clip] := offset (samples written), go IDLE.
//   - write of offset 2**DEPTH_W-1: len[clip] := 2**DEPTH_W (stored DEPTH_W+1 bits wide), go IDLE.
//   - A record rise in the same cycle as a tick: the tick's write completes first and is counted.
//   - Play rise during RECORD is ignored.
// - PLAY, each sample_tick_i: mem_re_o=1 with mem_addr_o={clip,offset}, offset += 1.
//   - The next cycle: spk_sample_o := mem_rdata_i, spk_valid_o=1.
//   - Latency from tick to spk_valid_o: 2 cycles.
// - PLAY exit:
//   - after the read of offset len[clip]-1, go IDLE; the final read still produces its spk_valid_o pulse.
//   - play rise: go IDLE with no further reads; a read already in flight still delivers.
//   - Record rise during PLAY is ignored.
// - mem_we_o and mem_re_o are never high together.
// - clip_o holds its value after returning to IDLE.
// - Async reset mid-operation: abort immediately and clear the length table (clips are treated as lost).
// CONFIGURATION
// - LOOP_PLAY_EN defined:
//   - on reaching len[clip], offset wraps to 0 and PLAY continues; exit only on play rise.
//   - no gap: the next tick reads offset 0.
// - LOOP_PLAY_EN undefined: one-shot playback as in BEHAVIOUR.
// TESTING (bench parameters NUM_CLIPS=4, DEPTH_W=4, SAMPLE_W=16)
// - Record clip 2, 5 ticks with samples 0x0101..0x0105, then record rise
//   -> writes to addresses 0x20..0x24; len[2]=5; state_o returns to 0.
// - Play clip 2 -> 5 spk_valid_o pulses carrying 0x0101..0x0105, each 2 cycles after its tick; then IDLE.
//   - With LOOP_PLAY_EN: the 6th pulse is 0x0101.
// - Play clip 1 after reset -> empty_err_o pulses once; state_o stays 0; no mem_re_o.
// - Record clip 3 for 20 ticks -> 16 writes (0x30..0x3F); auto-stop; len[3]=16.
// - Play and record rise in the same cycle in IDLE -> state_o=1.
//   - Play rise during RECORD -> ignored, no reads.
// - reset_n_i low mid-PLAY -> all outputs 0 at once; a later play of that clip -> empty_err_o.

Source files
------------

// File: rtl/clip_transport_ctrl.sv
// clip_transport_ctrl: multi-clip record/playback transport between the user
// controls and the sample store. Each clip owns a 2**DEPTH_W sample region
// addressed as {clip, offset}; a per-clip length table bounds playback.
// Optional build macro: LOOP_PLAY_EN (playback wraps to offset 0 at the
// recorded end and continues until the next play command).
module clip_transport_ctrl #(
  parameter int NUM_CLIPS = 4,
  parameter int DEPTH_W   = 16,
  parameter int SAMPLE_W  = 16,
  localparam int CLIP_W   = $clog2(NUM_CLIPS),
  localparam int ADDR_W   = CLIP_W + DEPTH_W
) (
  input  logic                clock_i,
  input  logic                reset_n_i,
  input  logic                play_i,
  input  logic                record_i,
  input  logic [CLIP_W-1:0]   play_clip_i,
  input  logic [CLIP_W-1:0]   record_clip_i,
  input  logic                sample_tick_i,
  input  logic [SAMPLE_W-1:0] mic_sample_i,
  output logic                mem_we_o,
  output logic                mem_re_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [SAMPLE_W-1:0] mem_wdata_o,
  input  logic [SAMPLE_W-1:0] mem_rdata_i,
  output logic [SAMPLE_W-1:0] spk_sample_o,
  output logic                spk_valid_o,
  output logic [1:0]          state_o,
  output logic [CLIP_W-1:0]   clip_o,
  output logic                empty_err_o
);

  // Lengths need one extra bit so a completely filled clip is representable.
  localparam int LEN_W = DEPTH_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } state_t;

  state_t                state_reg, state_next;
  logic                  play_q_reg, record_q_reg;
  logic                  play_rise, record_rise;
  logic [CLIP_W-1:0]     clip_reg, clip_next;
  logic [DEPTH_W-1:0]    offset_reg, offset_next;
  logic [LEN_W-1:0]      len_reg [NUM_CLIPS];
  logic [NUM_CLIPS-1:0]  len_hit;
  logic                  len_we;
  logic [LEN_W-1:0]      len_wval;
  logic                  mem_we_reg, mem_we_next;
  logic                  mem_re_reg, mem_re_next;
  logic [ADDR_W-1:0]     mem_addr_reg, mem_addr_next;
  logic [SAMPLE_W-1:0]   mem_wdata_reg, mem_wdata_next;
  logic                  spk_valid_reg;
  logic [SAMPLE_W-1:0]   spk_hold_reg;
  logic                  empty_err_reg, empty_err_next;
  logic [LEN_W-1:0]      offset_inc;
  logic                  last_offset;
  logic                  last_read;
  logic                  play_len_zero;

  assign play_rise     = play_i & ~play_q_reg;
  assign record_rise   = record_i & ~record_q_reg;
  assign offset_inc    = {1'b0, offset_reg} + LEN_W'(1);
  assign last_offset   = (offset_reg == {DEPTH_W{1'b1}});
  assign last_read     = (offset_inc == len_reg[clip_reg]);
  assign play_len_zero = (len_reg[play_clip_i] == '0);

  // Command edge detectors: remember last cycle's command levels.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      play_q_reg   <= 1'b0;
      record_q_reg <= 1'b0;
    end else begin
      play_q_reg   <= play_i;
      record_q_reg <= record_i;
    end
  end

  // State register.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) state_reg <= ST_IDLE;
    else            state_reg <= state_next;
  end

  // Next-state logic: record wins over play in IDLE; the other command is
  // ignored while a transport operation is active.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: begin
        if (record_rise)                      state_next = ST_RECORD;
        else if (play_rise && !play_len_zero) state_next = ST_PLAY;
      end
      ST_RECORD: begin
        if (record_rise || (sample_tick_i && last_offset)) state_next = ST_IDLE;
      end
`ifdef LOOP_PLAY_EN
      ST_PLAY: begin
        if (play_rise) state_next = ST_IDLE;
      end
`else
      ST_PLAY: begin
        if (play_rise || (sample_tick_i && last_read)) state_next = ST_IDLE;
      end
`endif
      default: state_next = ST_IDLE;
    endcase
  end

  // Output/datapath logic: memory strobes, offset and clip bookkeeping.
  always_comb begin
    clip_next      = clip_reg;
    offset_next    = offset_reg;
    mem_we_next    = 1'b0;
    mem_re_next    = 1'b0;
    mem_addr_next  = mem_addr_reg;
    mem_wdata_next = mem_wdata_reg;
    len_we         = 1'b0;
    len_wval       = offset_inc;
    empty_err_next = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (record_rise) begin
          clip_next   = record_clip_i;
          offset_next = '0;
        end else if (play_rise) begin
          if (play_len_zero) begin
            empty_err_next = 1'b1;
          end else begin
            clip_next   = play_clip_i;
            offset_next = '0;
          end
        end
      end
      ST_RECORD: begin
        if (sample_tick_i) begin
          mem_we_next    = 1'b1;
          mem_addr_next  = {clip_reg, offset_reg};
          mem_wdata_next = mic_sample_i;
          offset_next    = offset_reg + DEPTH_W'(1);
        end
        // A tick coinciding with the stop command is counted in the length.
        if (record_rise || (sample_tick_i && last_offset)) begin
          len_we   = 1'b1;
          len_wval = sample_tick_i ? offset_inc : {1'b0, offset_reg};
        end
      end
      ST_PLAY: begin
        // A play command stops immediately; no read is issued in its cycle.
        if (!play_rise && sample_tick_i) begin
          mem_re_next   = 1'b1;
          mem_addr_next = {clip_reg, offset_reg};
`ifdef LOOP_PLAY_EN
          offset_next   = last_read ? '0 : offset_reg + DEPTH_W'(1);
`else
          offset_next   = offset_reg + DEPTH_W'(1);
`endif
        end
      end
      default: ;
    endcase
  end

  // Per-clip length table write selects.
  for (genvar gi = 0; gi < NUM_CLIPS; gi++) begin : g_len_hit
    assign len_hit[gi] = len_we && (clip_reg == CLIP_W'(gi));
  end

  // Length table: cleared on reset, since clip contents are considered lost.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int i = 0; i < NUM_CLIPS; i++) len_reg[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CLIPS; i++) begin
        if (len_hit[i]) len_reg[i] <= len_wval;
      end
    end
  end

  // Datapath registers: memory interface, clip/offset and status pulses.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      clip_reg      <= '0;
      offset_reg    <= '0;
      mem_we_reg    <= 1'b0;
      mem_re_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      empty_err_reg <= 1'b0;
    end else begin
      clip_reg      <= clip_next;
      offset_reg    <= offset_next;
      mem_we_reg    <= mem_we_next;
      mem_re_reg    <= mem_re_next;
      mem_addr_reg  <= mem_addr_next;
      mem_wdata_reg <= mem_wdata_next;
      empty_err_reg <= empty_err_next;
    end
  end

  // Speaker path: read data arrives the cycle after mem_re_o; it is passed
  // straight through while valid and held afterwards.
  always_ff @(posedge clock_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      spk_valid_reg <= 1'b0;
      spk_hold_reg  <= '0;
    end else begin
      spk_valid_reg <= mem_re_reg;
      if (spk_valid_reg) spk_hold_reg <= mem_rdata_i;
    end
  end

  assign spk_sample_o = spk_valid_reg ? mem_rdata_i : spk_hold_reg;
  assign spk_valid_o  = spk_valid_reg;
  assign mem_we_o     = mem_we_reg;
  assign mem_re_o     = mem_re_reg;
  assign mem_addr_o   = mem_addr_reg;
  assign mem_wdata_o  = mem_wdata_reg;
  assign state_o      = state_reg;
  assign clip_o       = clip_reg;
  assign empty_err_o  = empty_err_reg;

endmodule

// File: tb/tb_clip_transport_ctrl.sv
// tb_clip_transport_ctrl: scoreboard bench for clip_transport_ctrl with a
// behavioural sample store (registered read) attached to the memory port.
module tb_clip_transport_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        play, record;
  logic [1:0]  play_clip, record_clip;
  logic        tick;
  logic [15:0] mic;
  logic        mem_we, mem_re;
  logic [5:0]  mem_addr;
  logic [15:0] mem_wdata, mem_rdata;
  logic [15:0] spk_sample;
  logic        spk_valid;
  logic [1:0]  state;
  logic [1:0]  clip;
  logic        empty_err;

  clip_transport_ctrl #(.NUM_CLIPS(4), .DEPTH_W(4), .SAMPLE_W(16)) dut (
    .clock_i(clk), .reset_n_i(rst_n), .play_i(play), .record_i(record),
    .play_clip_i(play_clip), .record_clip_i(record_clip),
    .sample_tick_i(tick), .mic_sample_i(mic),
    .mem_we_o(mem_we), .mem_re_o(mem_re), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mem_rdata),
    .spk_sample_o(spk_sample), .spk_valid_o(spk_valid),
    .state_o(state), .clip_o(clip), .empty_err_o(empty_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Sample store with a one-cycle registered read.
  logic [15:0] store [64];
  always @(posedge clk) begin
    if (mem_we) store[mem_addr] <= mem_wdata;
    if (mem_re) mem_rdata <= store[mem_addr];
  end

  typedef struct { logic [5:0] addr; logic [15:0] data; int cyc; } wr_t;
  typedef struct { logic [15:0] data; int cyc; } rd_t;
  wr_t wr_q[$];
  rd_t spk_q[$];
  wr_t wr_e;
  rd_t rd_e;

  int total = 0, bad = 0;
  int we_cnt = 0, re_cnt = 0, err_cnt = 0, both_cnt = 0, extra_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end else begin
      $display("chk %s ok val=%0h", tag, got);
    end
  endtask

  // Monitor: pops scoreboard entries as the DUT produces writes and samples.
  always @(negedge clk) begin
    if (mem_we && mem_re) both_cnt++;
    if (mem_re) re_cnt++;
    if (empty_err) err_cnt++;
    if (mem_we) begin
      we_cnt++;
      if (wr_q.size() > 0) begin
        wr_e = wr_q.pop_front();
        check_eq("wr_addr", 32'(mem_addr), 32'(wr_e.addr));
        check_eq("wr_data", 32'(mem_wdata), 32'(wr_e.data));
        check_eq("wr_lat", 32'(cyc), 32'(wr_e.cyc + 1));
      end else extra_cnt++;
    end
    if (spk_valid) begin
      if (spk_q.size() > 0) begin
        rd_e = spk_q.pop_front();
        check_eq("spk_data", 32'(spk_sample), 32'(rd_e.data));
        check_eq("spk_lat", 32'(cyc), 32'(rd_e.cyc + 2));
      end else extra_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_record(input logic [1:0] c);
    record_clip = c; record = 1'b1; step(1); record = 1'b0;
  endtask

  task automatic pulse_play(input logic [1:0] c);
    play_clip = c; play = 1'b1; step(1); play = 1'b0;
  endtask

  task automatic do_tick(input logic [15:0] s);
    mic = s; tick = 1'b1; step(1); tick = 1'b0; step(1);
  endtask

  task automatic exp_wr(input int a, input int d);
    wr_q.push_back('{addr: 6'(a), data: 16'(d), cyc: cyc});
  endtask

  task automatic exp_spk(input int d);
    spk_q.push_back('{data: 16'(d), cyc: cyc});
  endtask

  int n0, e0;

  initial begin
    rst_n = 1'b0; play = 1'b0; record = 1'b0; play_clip = '0; record_clip = '0;
    tick = 1'b0; mic = '0;
    step(3);
    check_eq("rst_state", 32'(state), 32'd0);
    check_eq("rst_clip", 32'(clip), 32'd0);
    check_eq("rst_we", 32'(mem_we), 32'd0);
    check_eq("rst_re", 32'(mem_re), 32'd0);
    check_eq("rst_addr", 32'(mem_addr), 32'd0);
    check_eq("rst_wdata", 32'(mem_wdata), 32'd0);
    check_eq("rst_spk", 32'(spk_sample), 32'd0);
    check_eq("rst_spkv", 32'(spk_valid), 32'd0);
    check_eq("rst_err", 32'(empty_err), 32'd0);
    rst_n = 1'b1;
    step(1);

    // Record five samples into clip 2.
    pulse_record(2'd2);
    check_eq("rec_state", 32'(state), 32'd1);
    check_eq("rec_clip", 32'(clip), 32'd2);
    for (int i = 0; i < 5; i++) begin
      exp_wr(32'h20 + i, 32'h0101 + i);
      do_tick(16'(32'h0101 + i));
    end
    pulse_record(2'd0);
    check_eq("rec_stop_state", 32'(state), 32'd0);
    check_eq("clip_hold", 32'(clip), 32'd2);
    step(2);
    check_eq("rec_we_cnt", 32'(we_cnt), 32'd5);
    check_eq("rec_q_left", 32'(wr_q.size()), 32'd0);

    // Play clip 2 back.
    n0 = re_cnt;
    pulse_play(2'd2);
    check_eq("play_state", 32'(state), 32'd2);
    check_eq("play_clip", 32'(clip), 32'd2);
    for (int i = 0; i < 5; i++) begin
      exp_spk(32'h0101 + i);
      do_tick(16'h0);
    end
`ifdef LOOP_PLAY_EN
    check_eq("loop_state", 32'(state), 32'd2);
    exp_spk(32'h0101);
    do_tick(16'h0);
    pulse_play(2'd2);
    check_eq("loop_stop_state", 32'(state), 32'd0);
    step(3);
    check_eq("play_re_cnt", 32'(re_cnt - n0), 32'd6);
`else
    check_eq("play_end_state", 32'(state), 32'd0);
    do_tick(16'h0);
    step(3);
    check_eq("play_re_cnt", 32'(re_cnt - n0), 32'd5);
`endif
    check_eq("play_q_left", 32'(spk_q.size()), 32'd0);

    // Play an empty clip.
    n0 = re_cnt; e0 = err_cnt;
    pulse_play(2'd1);
    step(2);
    check_eq("empty_err_cnt", 32'(err_cnt - e0), 32'd1);
    check_eq("empty_state", 32'(state), 32'd0);
    check_eq("empty_no_re", 32'(re_cnt - n0), 32'd0);

    // Record clip 3 past its capacity: auto-stop after 16 writes.
    n0 = we_cnt;
    pulse_record(2'd3);
    for (int i = 0; i < 20; i++) begin
      if (i < 16) exp_wr(32'h30 + i, 32'h3000 + i);
      do_tick(16'(32'h3000 + i));
    end
    step(2);
    check_eq("full_state", 32'(state), 32'd0);
    check_eq("full_we_cnt", 32'(we_cnt - n0), 32'd16);
    check_eq("full_q_left", 32'(wr_q.size()), 32'd0);
    pulse_play(2'd3);
    for (int i = 0; i < 16; i++) begin
      exp_spk(32'h3000 + i);
      do_tick(16'h0);
    end
`ifdef LOOP_PLAY_EN
    pulse_play(2'd3);
`endif
    check_eq("full_play_end", 32'(state), 32'd0);
    step(3);
    check_eq("full_play_q", 32'(spk_q.size()), 32'd0);

    // Simultaneous play and record rise: record wins; play is then ignored.
    n0 = re_cnt;
    play_clip = 2'd2; record_clip = 2'd0; play = 1'b1; record = 1'b1;
    step(1);
    play = 1'b0; record = 1'b0;
    check_eq("both_state", 32'(state), 32'd1);
    check_eq("both_clip", 32'(clip), 32'd0);
    pulse_play(2'd2);
    step(1);
    check_eq("rec_ignore_play", 32'(state), 32'd1);
    pulse_record(2'd0);
    check_eq("both_exit", 32'(state), 32'd0);
    check_eq("both_no_re", 32'(re_cnt - n0), 32'd0);

    // Reset in the middle of playback.
    pulse_play(2'd2);
    exp_spk(32'h0101); do_tick(16'h0);
    exp_spk(32'h0102); do_tick(16'h0);
    step(2);
    check_eq("mid_state", 32'(state), 32'd2);
    check_eq("mid_spk_hold", 32'(spk_sample), 32'h0102);
    tick = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0; tick = 1'b0;
    #1;
    spk_q.delete();
    check_eq("ar_state", 32'(state), 32'd0);
    check_eq("ar_clip", 32'(clip), 32'd0);
    check_eq("ar_re", 32'(mem_re), 32'd0);
    check_eq("ar_addr", 32'(mem_addr), 32'd0);
    check_eq("ar_spk", 32'(spk_sample), 32'd0);
    check_eq("ar_spkv", 32'(spk_valid), 32'd0);
    step(1);
    rst_n = 1'b1;
    step(1);
    e0 = err_cnt;
    pulse_play(2'd2);
    step(2);
    check_eq("ar_empty_err", 32'(err_cnt - e0), 32'd1);
    check_eq("ar_idle", 32'(state), 32'd0);

    step(3);
    check_eq("we_re_excl", 32'(both_cnt), 32'd0);
    check_eq("unexpected_out", 32'(extra_cnt), 32'd0);
    check_eq("final_wr_q", 32'(wr_q.size()), 32'd0);
    check_eq("final_spk_q", 32'(spk_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
